// File: rtl/mem_frame_scheduler.sv
// mem_frame_scheduler: round-robin arbiter that admits whole frames from three
// sources into a circular bank and emits one descriptor per frame (normal or error).
module mem_frame_scheduler #(
    parameter int pDATA_WIDTH = 32,
    parameter int pADDR_WIDTH = 10,
    parameter int pMAX_WORDS  = 381,
    parameter int pTIMEOUT    = 64
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic [2:0]                         i_valid,
    input  logic [pDATA_WIDTH-1:0]             i_data_port1,
    input  logic [pDATA_WIDTH-1:0]             i_data_port2,
    input  logic [pDATA_WIDTH-1:0]             i_data_port3,
    input  logic [1:0]                         i_info_port1,
    input  logic [1:0]                         i_info_port2,
    input  logic [1:0]                         i_info_port3,
    input  logic [1:0]                         i_extra_byte1,
    input  logic [1:0]                         i_extra_byte2,
    input  logic [1:0]                         i_extra_byte3,
    input  logic [pADDR_WIDTH:0]               i_free_words,
    output logic [2:0]                         o_grant,
    output logic                               o_wr_en,
    output logic [pADDR_WIDTH-1:0]             o_wr_addr,
    output logic [pDATA_WIDTH-1:0]             o_wr_data,
    output logic                               o_desc_valid,
    output logic [pADDR_WIDTH-1:0]             o_desc_addr,
    output logic [$clog2(pMAX_WORDS+1)-1:0]    o_desc_len,
    output logic [1:0]                         o_desc_src,
    output logic [1:0]                         o_desc_extra,
    output logic                               o_desc_err,
    output logic                               o_busy
);
    localparam int LEN_W = $clog2(pMAX_WORDS + 1);
    localparam int TO_W  = $clog2(pTIMEOUT + 1);
    localparam logic [LEN_W-1:0]     LAST_CNT = LEN_W'(pMAX_WORDS - 1);
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(pTIMEOUT - 1);
    localparam logic [pADDR_WIDTH:0] FREE_MIN = (pADDR_WIDTH + 1)'(pMAX_WORDS);

    // S_DESC is a reserved encoding; it is never entered and recovers to S_IDLE.
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_FLUSH, S_DESC} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               grant_q, grant_d;
    logic [1:0]               last_q, last_d;
    logic [pADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, start_q, start_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [TO_W-1:0]          idle_q, idle_d;
    logic                     wr_en_q, wr_en_d;
    logic [pADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [pDATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                     desc_valid_q, desc_valid_d;
    logic [pADDR_WIDTH-1:0]   desc_addr_q, desc_addr_d;
    logic [LEN_W-1:0]         desc_len_q, desc_len_d;
    logic [1:0]               desc_src_q, desc_src_d;
    logic [1:0]               desc_extra_q, desc_extra_d;
    logic                     desc_err_q, desc_err_d;

    logic                     acc, end_acc, mid_start, over, idle_hit, can_grant, win_hit;
    logic [pDATA_WIDTH-1:0]   acc_data;
    logic [1:0]               acc_info, acc_extra, winner, src_idx, p0, p1;
    logic [2:0]               req_vec;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Decode the accepted word, the round-robin winner and the frame events.
    always_comb begin
        acc       = |(i_valid & grant_q);
        acc_data  = '0;
        acc_info  = '0;
        acc_extra = '0;
        src_idx   = 2'd0;
        if (grant_q[0]) begin
            acc_data = i_data_port1; acc_info = i_info_port1; acc_extra = i_extra_byte1;
        end else if (grant_q[1]) begin
            acc_data = i_data_port2; acc_info = i_info_port2; acc_extra = i_extra_byte2;
            src_idx  = 2'd1;
        end else if (grant_q[2]) begin
            acc_data = i_data_port3; acc_info = i_info_port3; acc_extra = i_extra_byte3;
            src_idx  = 2'd2;
        end
        req_vec = i_valid & {i_info_port3[0], i_info_port2[0], i_info_port1[0]};
        p0      = next_idx(last_q);
        p1      = next_idx(p0);
        win_hit = 1'b1;
        if (req_vec[p0])          winner = p0;
        else if (req_vec[p1])     winner = p1;
        else if (req_vec[last_q]) winner = last_q;
        else begin
            winner  = 2'd0;
            win_hit = 1'b0;
        end
        can_grant = win_hit && (i_free_words >= FREE_MIN);
        // A start bit after the first word means the source restarted mid-frame.
        mid_start = acc && acc_info[0] && (cnt_q != '0);
        end_acc   = acc && acc_info[1];
        over      = acc && !acc_info[1] && !mid_start && (cnt_q == LAST_CNT);
        idle_hit  = !acc && (idle_q == TO_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (can_grant) state_d = S_XFER;
            // A restart word that is also an end word closes the frame outright.
            S_XFER:  if (mid_start)     state_d = acc_info[1] ? S_IDLE : S_FLUSH;
                     else if (end_acc)  state_d = S_IDLE;
                     else if (over)     state_d = S_FLUSH;
                     else if (idle_hit) state_d = S_IDLE;
            S_FLUSH: if (end_acc || idle_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Grant, write port, descriptor and pointer updates per state.
    always_comb begin
        grant_d      = grant_q;
        last_d       = last_q;
        wr_ptr_d     = wr_ptr_q;
        start_d      = start_q;
        cnt_d        = cnt_q;
        idle_d       = idle_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        desc_valid_d = 1'b0;
        desc_addr_d  = desc_addr_q;
        desc_len_d   = desc_len_q;
        desc_src_d   = desc_src_q;
        desc_extra_d = desc_extra_q;
        desc_err_d   = desc_err_q;
        case (state_q)
            S_IDLE: begin
                idle_d = '0;
                if (can_grant) begin
                    grant_d = 3'(3'b001 << winner);
                    last_d  = winner;
                    start_d = wr_ptr_q;
                    cnt_d   = '0;
                end
            end
            S_XFER: begin
                idle_d      = (acc || idle_hit) ? '0 : idle_q + TO_W'(1);
                desc_addr_d = start_q;
                desc_src_d  = src_idx;
                if (mid_start || idle_hit) begin
                    // Drop the frame: report what was written and reclaim the space.
                    desc_valid_d = 1'b1;
                    desc_len_d   = cnt_q;
                    desc_extra_d = 2'b00;
                    desc_err_d   = 1'b1;
                    wr_ptr_d     = start_q;
                    if (idle_hit || acc_info[1]) grant_d = '0;
                end else if (acc) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_ptr_q;
                    wr_data_d = acc_data;
                    wr_ptr_d  = wr_ptr_q + pADDR_WIDTH'(1);
                    cnt_d     = cnt_q + LEN_W'(1);
                    if (acc_info[1]) begin
                        desc_valid_d = 1'b1;
                        desc_len_d   = cnt_q + LEN_W'(1);
                        desc_extra_d = acc_extra;
                        desc_err_d   = 1'b0;
                        grant_d      = '0;
                    end else if (over) begin
                        desc_valid_d = 1'b1;
                        desc_len_d   = cnt_q + LEN_W'(1);
                        desc_extra_d = 2'b00;
                        desc_err_d   = 1'b1;
                        wr_ptr_d     = start_q;
                    end
                end
            end
            S_FLUSH: begin
                idle_d = (acc || idle_hit) ? '0 : idle_q + TO_W'(1);
                if (end_acc || idle_hit) grant_d = '0;
            end
            default: grant_d = '0;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_q       <= 2'd2;
            wr_ptr_q     <= '0;
            start_q      <= '0;
            cnt_q        <= '0;
            idle_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            desc_valid_q <= 1'b0;
            desc_addr_q  <= '0;
            desc_len_q   <= '0;
            desc_src_q   <= '0;
            desc_extra_q <= '0;
            desc_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            wr_ptr_q     <= wr_ptr_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            desc_valid_q <= desc_valid_d;
            desc_addr_q  <= desc_addr_d;
            desc_len_q   <= desc_len_d;
            desc_src_q   <= desc_src_d;
            desc_extra_q <= desc_extra_d;
            desc_err_q   <= desc_err_d;
        end
    end

    assign o_grant      = grant_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_desc_valid = desc_valid_q;
    assign o_desc_addr  = desc_addr_q;
    assign o_desc_len   = desc_len_q;
    assign o_desc_src   = desc_src_q;
    assign o_desc_extra = desc_extra_q;
    assign o_desc_err   = desc_err_q;
    assign o_busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_frame_scheduler.sv
// tb_mem_frame_scheduler: directed frames with a write/descriptor scoreboard.
module tb_mem_frame_scheduler;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int MW = 381;
    localparam int LW = $clog2(MW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tdata [3];
    logic [1:0]    tinfo [3];
    logic [1:0]    text  [3];
    logic          tvld  [3];
    logic [2:0]    i_valid;
    logic [AW:0]   free;

    logic [2:0]    o_grant;
    logic          o_wr_en, o_desc_valid, o_desc_err, o_busy;
    logic [AW-1:0] o_wr_addr, o_desc_addr;
    logic [DW-1:0] o_wr_data;
    logic [LW-1:0] o_desc_len;
    logic [1:0]    o_desc_src, o_desc_extra;

    assign i_valid = {tvld[2], tvld[1], tvld[0]};

    always #5 clk = ~clk;

    mem_frame_scheduler dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid),
        .i_data_port1(tdata[0]), .i_data_port2(tdata[1]), .i_data_port3(tdata[2]),
        .i_info_port1(tinfo[0]), .i_info_port2(tinfo[1]), .i_info_port3(tinfo[2]),
        .i_extra_byte1(text[0]), .i_extra_byte2(text[1]), .i_extra_byte3(text[2]),
        .i_free_words(free), .o_grant(o_grant), .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_desc_valid(o_desc_valid),
        .o_desc_addr(o_desc_addr), .o_desc_len(o_desc_len), .o_desc_src(o_desc_src),
        .o_desc_extra(o_desc_extra), .o_desc_err(o_desc_err), .o_busy(o_busy)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [1:0]    src;
        logic [1:0]    extra;
        logic          err;
    } desc_t;

    wr_t   exp_wr[$];
    desc_t exp_desc[$];
    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic exp_frame(input int start, input int n, input logic [DW-1:0] base);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = AW'((start + i) % (1 << AW));
            w.data = base + DW'(i);
            exp_wr.push_back(w);
        end
    endtask

    task automatic exp_d(input int addr, input int len, input int src,
                         input logic [1:0] extra, input logic err);
        desc_t d;
        d.addr = AW'(addr); d.len = LW'(len); d.src = 2'(src); d.extra = extra; d.err = err;
        exp_desc.push_back(d);
    endtask

    // Present one word on port k and hold it until the DUT accepts it.
    task automatic send_word(input int k, input logic [DW-1:0] d,
                             input logic [1:0] inf, input logic [1:0] ex);
        bit ok = 1'b0;
        tdata[k] = d; tinfo[k] = inf; text[k] = ex; tvld[k] = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (o_grant[k]) begin ok = 1'b1; break; end
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            total++; bad++;
            $display("FAIL accept_wait port%0d: got no grant in 1000 cycles exp grant", k + 1);
            tvld[k] = 1'b0;
        end
    endtask

    task automatic send_frame(input int k, input int n, input logic [DW-1:0] base,
                              input logic [1:0] ex, input bit with_end);
        logic [1:0] inf;
        for (int i = 0; i < n; i++) begin
            inf[0] = (i == 0);
            inf[1] = with_end && (i == n - 1);
            send_word(k, base + DW'(i), inf, (i == n - 1) ? ex : 2'b00);
        end
        tvld[k] = 1'b0;
    endtask

    // Monitor: compare every write and descriptor against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("grant_onehot", 64'(($countones(o_grant) <= 1) && (o_grant == 3'b000 || o_busy)), 64'(1));
            if (o_wr_en) begin
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h exp none", o_wr_addr, o_wr_data);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("write", 64'({o_wr_addr, o_wr_data}), 64'(e));
                end
            end
            if (o_desc_valid) begin
                if (exp_desc.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_desc: got addr=%0h len=%0d err=%0b exp none",
                             o_desc_addr, o_desc_len, o_desc_err);
                end else begin
                    desc_t e;
                    e = exp_desc.pop_front();
                    chk("desc", 64'({o_desc_addr, o_desc_len, o_desc_src, o_desc_extra, o_desc_err}), 64'(e));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; free = 11'd1024;
        for (int k = 0; k < 3; k++) begin
            tdata[k] = '0; tinfo[k] = '0; text[k] = '0; tvld[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(o_grant), 64'(0));
        chk("rst_wr_en", 64'(o_wr_en), 64'(0));
        chk("rst_wr_addr", 64'(o_wr_addr), 64'(0));
        chk("rst_wr_data", 64'(o_wr_data), 64'(0));
        chk("rst_desc_valid", 64'(o_desc_valid), 64'(0));
        chk("rst_desc_fields", 64'({o_desc_addr, o_desc_len, o_desc_src, o_desc_extra, o_desc_err}), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Three simultaneous requests: port1, port2, port3 in turn.
        exp_frame(0, 4, 32'hA001_0000); exp_d(0, 4, 0, 2'b01, 1'b0);
        exp_frame(4, 4, 32'hA002_0000); exp_d(4, 4, 1, 2'b10, 1'b0);
        exp_frame(8, 4, 32'hA003_0000); exp_d(8, 4, 2, 2'b11, 1'b0);
        fork
            send_frame(0, 4, 32'hA001_0000, 2'b01, 1'b1);
            send_frame(1, 4, 32'hA002_0000, 2'b10, 1'b1);
            send_frame(2, 4, 32'hA003_0000, 2'b11, 1'b1);
        join
        repeat (3) @(posedge clk); #1;

        // Free-space gating.
        free = 11'd380;
        exp_frame(12, 2, 32'hA004_0000); exp_d(12, 2, 0, 2'b00, 1'b0);
        fork
            send_frame(0, 2, 32'hA004_0000, 2'b00, 1'b1);
        join_none
        repeat (5) begin
            @(negedge clk);
            chk("gate_380", 64'(o_grant), 64'(0));
        end
        @(posedge clk); #1;
        free = 11'd381;
        @(negedge clk);
        chk("gate_edge", 64'(o_grant), 64'(0));
        @(negedge clk);
        chk("gate_381", 64'(o_grant), 64'(3'b001));
        wait fork;
        free = 11'd1024;
        repeat (2) @(posedge clk); #1;

        // Timeout after three words.
        exp_frame(14, 3, 32'hA005_0000); exp_d(14, 3, 1, 2'b00, 1'b1);
        send_frame(1, 3, 32'hA005_0000, 2'b00, 1'b0);
        repeat (63) @(posedge clk);
        @(negedge clk);
        chk("timeout_hold", 64'(o_grant), 64'(3'b010));
        @(negedge clk);
        chk("timeout_clear", 64'(o_grant), 64'(0));
        chk("timeout_desc", 64'(o_desc_valid), 64'(1));
        chk("timeout_idle", 64'(o_busy), 64'(0));
        exp_frame(14, 2, 32'hA006_0000); exp_d(14, 2, 1, 2'b01, 1'b0);
        send_frame(1, 2, 32'hA006_0000, 2'b01, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Start word mid-frame, then the flushed end word.
        exp_frame(16, 2, 32'hA007_0000); exp_d(16, 2, 2, 2'b00, 1'b1);
        send_word(2, 32'hA007_0000, 2'b01, 2'b00);
        send_word(2, 32'hA007_0001, 2'b00, 2'b00);
        send_word(2, 32'hDEAD_0001, 2'b01, 2'b00);
        send_word(2, 32'hDEAD_0002, 2'b10, 2'b11);
        tvld[2] = 1'b0;
        @(negedge clk);
        chk("restart_idle", 64'({o_busy, o_grant}), 64'(0));
        repeat (2) @(posedge clk); #1;

        // Overlength frame of 383 words.
        exp_frame(16, 381, 32'hA008_0000); exp_d(16, 381, 0, 2'b00, 1'b1);
        send_frame(0, 383, 32'hA008_0000, 2'b11, 1'b1);
        @(negedge clk);
        chk("over_idle", 64'({o_busy, o_grant}), 64'(0));
        repeat (2) @(posedge clk); #1;

        // Fill up to address 1022 (pointer restored to 16 above).
        exp_frame(16, 381, 32'hA009_0000);  exp_d(16, 381, 0, 2'b00, 1'b0);
        send_frame(0, 381, 32'hA009_0000, 2'b00, 1'b1);
        exp_frame(397, 381, 32'hA00A_0000); exp_d(397, 381, 0, 2'b00, 1'b0);
        send_frame(0, 381, 32'hA00A_0000, 2'b00, 1'b1);
        exp_frame(778, 244, 32'hA00B_0000); exp_d(778, 244, 0, 2'b00, 1'b0);
        send_frame(0, 244, 32'hA00B_0000, 2'b00, 1'b1);

        // Single-word frame at 1022, then a frame that wraps.
        exp_frame(1022, 1, 32'hA00C_0000); exp_d(1022, 1, 1, 2'b10, 1'b0);
        send_frame(1, 1, 32'hA00C_0000, 2'b10, 1'b1);
        exp_frame(1023, 3, 32'hA00D_0000); exp_d(1023, 3, 1, 2'b00, 1'b0);
        send_frame(1, 3, 32'hA00D_0000, 2'b00, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Reset pulse mid-frame: two words written, no descriptor.
        exp_frame(2, 2, 32'hA00E_0000);
        send_word(0, 32'hA00E_0000, 2'b01, 2'b00);
        send_word(0, 32'hA00E_0001, 2'b00, 2'b00);
        tvld[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_grant", 64'(o_grant), 64'(0));
        chk("midrst_wr_en", 64'(o_wr_en), 64'(0));
        chk("midrst_desc", 64'(o_desc_valid), 64'(0));
        chk("midrst_busy", 64'(o_busy), 64'(0));
        exp_frame(0, 2, 32'hA00F_0000); exp_d(0, 2, 0, 2'b01, 1'b0);
        send_frame(0, 2, 32'hA00F_0000, 2'b01, 1'b1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
        chk("desc_queue_empty", 64'(exp_desc.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
